// File: rtl/power_ramp_sequencer.sv
// Staircase sequencer for the toggle-bank enables: ramps the enabled-bank count
// up to a captured target, holds, then ramps back to zero.
//
// state     | meaning
// IDLE      | waiting for start, all banks off
// RAMP_UP   | level +1 every dwell period until it reaches the target
// HOLD      | level parked at the target for the hold period
// RAMP_DOWN | level -1 every dwell period until zero
// DONE      | one-cycle completion pulse, then back to IDLE
module power_ramp_sequencer #(
  parameter int NUM_BANKS = 8,
  parameter int DWELL_W   = 8,
  parameter int HOLD_W    = 8,
  localparam int LW       = $clog2(NUM_BANKS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 abort,
  input  logic [LW-1:0]        target_level,
  input  logic [DWELL_W-1:0]   dwell_cfg,
  input  logic [HOLD_W-1:0]    hold_cfg,
  output logic [NUM_BANKS-1:0] bank_en,
  output logic [LW-1:0]        level,
  output logic [2:0]           state,
  output logic                 busy,
  output logic                 done,
  output logic [7:0]           run_count
);

  localparam int CW = (DWELL_W > HOLD_W) ? DWELL_W : HOLD_W;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RAMP_UP   = 3'd1,
    S_HOLD      = 3'd2,
    S_RAMP_DOWN = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  state_t               state_q, state_nxt;
  logic [LW-1:0]        level_q, level_nxt;
  logic [LW-1:0]        tgt_q, tgt_nxt, tgt_in;
  logic [DWELL_W-1:0]   dwell_q, dwell_nxt, dwell_in;
  logic [HOLD_W-1:0]    hold_q, hold_nxt, hold_in;
  logic [CW-1:0]        cnt_q, cnt_nxt, dwell_last, hold_last;
  logic [NUM_BANKS-1:0] bank_en_q, bank_en_nxt;
  logic                 busy_q, busy_nxt, done_q, done_nxt;
  logic [7:0]           run_count_q, run_count_nxt;
  logic                 dwell_tc, hold_tc, go;

  // Configuration is sanitised here and only ever sampled at start.
  assign tgt_in     = (target_level > LW'(NUM_BANKS)) ? LW'(NUM_BANKS) : target_level;
  assign dwell_in   = (dwell_cfg == '0) ? DWELL_W'(1) : dwell_cfg;
  assign hold_in    = (hold_cfg == '0) ? HOLD_W'(1) : hold_cfg;
  assign dwell_last = CW'(dwell_q) - CW'(1);
  assign hold_last  = CW'(hold_q) - CW'(1);
  assign dwell_tc   = (cnt_q == dwell_last);
  assign hold_tc    = (cnt_q == hold_last);
  assign go         = start && !abort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      level_q     <= '0;
      tgt_q       <= '0;
      dwell_q     <= '0;
      hold_q      <= '0;
      cnt_q       <= '0;
      bank_en_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      run_count_q <= '0;
    end else begin
      state_q     <= state_nxt;
      level_q     <= level_nxt;
      tgt_q       <= tgt_nxt;
      dwell_q     <= dwell_nxt;
      hold_q      <= hold_nxt;
      cnt_q       <= cnt_nxt;
      bank_en_q   <= bank_en_nxt;
      busy_q      <= busy_nxt;
      done_q      <= done_nxt;
      run_count_q <= run_count_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    if (ena) begin
      case (state_q)
        S_IDLE:      if (go) state_nxt = (tgt_in == '0) ? S_DONE : S_RAMP_UP;
        S_RAMP_UP: begin
          if (abort)                                      state_nxt = S_IDLE;
          else if (stop)                                  state_nxt = (level_q == '0) ? S_DONE : S_RAMP_DOWN;
          else if (dwell_tc && (level_q + LW'(1) == tgt_q)) state_nxt = S_HOLD;
        end
        S_HOLD: begin
          if (abort)                state_nxt = S_IDLE;
          else if (stop || hold_tc) state_nxt = S_RAMP_DOWN;
        end
        S_RAMP_DOWN: begin
          if (abort)                                 state_nxt = S_IDLE;
          else if (dwell_tc && (level_q == LW'(1))) state_nxt = S_DONE;
        end
        default:     state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    level_nxt = level_q;
    tgt_nxt   = tgt_q;
    dwell_nxt = dwell_q;
    hold_nxt  = hold_q;
    cnt_nxt   = cnt_q;
    if (ena) begin
      case (state_q)
        S_IDLE: if (go) begin
          tgt_nxt   = tgt_in;
          dwell_nxt = dwell_in;
          hold_nxt  = hold_in;
          cnt_nxt   = '0;
        end
        S_RAMP_UP: begin
          if (abort) begin
            level_nxt = '0;
            cnt_nxt   = '0;
          end else if (stop) begin
            cnt_nxt   = '0;
          end else if (dwell_tc) begin
            if (level_q < tgt_q) level_nxt = level_q + LW'(1);
            cnt_nxt = '0;
          end else begin
            cnt_nxt = cnt_q + CW'(1);
          end
        end
        S_HOLD: begin
          if (abort) begin
            level_nxt = '0;
            cnt_nxt   = '0;
          end else if (stop || hold_tc) begin
            cnt_nxt   = '0;
          end else begin
            cnt_nxt   = cnt_q + CW'(1);
          end
        end
        S_RAMP_DOWN: begin
          if (abort) begin
            level_nxt = '0;
            cnt_nxt   = '0;
          end else if (dwell_tc) begin
            if (level_q != '0) level_nxt = level_q - LW'(1);
            cnt_nxt = '0;
          end else begin
            cnt_nxt = cnt_q + CW'(1);
          end
        end
        default: begin
          level_nxt = '0;
          cnt_nxt   = '0;
        end
      endcase
    end

    for (int i = 0; i < NUM_BANKS; i++) bank_en_nxt[i] = (level_nxt > LW'(i));
    busy_nxt      = (state_nxt == S_RAMP_UP) || (state_nxt == S_HOLD) || (state_nxt == S_RAMP_DOWN);
    done_nxt      = (state_nxt == S_DONE);
    run_count_nxt = run_count_q;
    if ((state_nxt == S_DONE) && (state_q != S_DONE)) run_count_nxt = run_count_q + 8'd1;
  end

  assign bank_en   = bank_en_q;
  assign level     = level_q;
  assign state     = state_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign run_count = run_count_q;

endmodule

// File: tb/tb_power_ramp_sequencer.sv
// Scoreboard bench for power_ramp_sequencer: stimulus pushes hand-derived
// per-edge snapshots and done pulses; a negedge monitor pops and compares.
module tb_power_ramp_sequencer;

  localparam logic [2:0] IDLE = 3'd0, RU = 3'd1, HO = 3'd2, RD = 3'd3, DN = 3'd4;

  logic       clk = 1'b0;
  logic       rst, ena, start, stop, abort;
  logic [3:0] target_level;
  logic [7:0] dwell_cfg, hold_cfg;
  logic [7:0] bank_en;
  logic [3:0] level;
  logic [2:0] state;
  logic       busy, done;
  logic [7:0] run_count;

  power_ramp_sequencer #(.NUM_BANKS(8), .DWELL_W(8), .HOLD_W(8)) dut (
    .clk(clk), .rst(rst), .ena(ena), .start(start), .stop(stop), .abort(abort),
    .target_level(target_level), .dwell_cfg(dwell_cfg), .hold_cfg(hold_cfg),
    .bank_en(bank_en), .level(level), .state(state), .busy(busy), .done(done),
    .run_count(run_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [2:0] st;
    logic [3:0] lvl;
    logic [7:0] ben;
    logic       busy;
    logic       done;
    logic [7:0] rc;
    string      name;
  } snap_t;

  snap_t      exp_q[$];
  logic [7:0] done_q[$];
  snap_t      e;
  logic [7:0] d;
  int         cyc = 0;
  int         base = 0;
  int         n_vec = 0;
  int         n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] therm(input int n);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) if (i < n) r[i] = 1'b1;
    return r;
  endfunction

  task automatic expect_at(input int k, input logic [2:0] st, input int lvl, input int rc,
                           input string name);
    snap_t s;
    s.cyc  = base + k;
    s.st   = st;
    s.lvl  = 4'(lvl);
    s.ben  = therm(lvl);
    s.busy = (st == RU) || (st == HO) || (st == RD);
    s.done = (st == DN);
    s.rc   = 8'(rc);
    s.name = name;
    exp_q.push_back(s);
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      n_vec++;
      if (e.cyc < cyc) begin
        n_err++;
        $display("FAIL %s: snapshot for cycle %0d not sampled (now %0d)", e.name, e.cyc, cyc);
      end else if (state !== e.st || level !== e.lvl || bank_en !== e.ben || busy !== e.busy ||
                   done !== e.done || run_count !== e.rc) begin
        n_err++;
        $display("FAIL %s @%0d: got st=%0d lvl=%0d ben=%h busy=%b done=%b rc=%0d, want st=%0d lvl=%0d ben=%h busy=%b done=%b rc=%0d",
                 e.name, cyc, state, level, bank_en, busy, done, run_count,
                 e.st, e.lvl, e.ben, e.busy, e.done, e.rc);
      end
    end
    if (done === 1'b1) begin
      n_vec++;
      if (done_q.size() == 0) begin
        n_err++;
        $display("FAIL done_pulse @%0d: got unexpected done (run_count=%0d), want none", cyc, run_count);
      end else begin
        d = done_q.pop_front();
        if (run_count !== d) begin
          n_err++;
          $display("FAIL done_run_count @%0d: got %0d, want %0d", cyc, run_count, d);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start pulse sampled on the next edge (edge 0 of the run); config scrambled afterwards.
  task automatic start_run(input int t, input int dw, input int ho);
    target_level = 4'(t);
    dwell_cfg    = 8'(dw);
    hold_cfg     = 8'(ho);
    start        = 1'b1;
    tick();
    start        = 1'b0;
    target_level = 4'($urandom);
    dwell_cfg    = 8'($urandom);
    hold_cfg     = 8'($urandom);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ena = 1'b1; start = 1'b0; stop = 1'b0; abort = 1'b0;
    target_level = '0; dwell_cfg = '0; hold_cfg = '0;
    repeat (3) tick();
    rst = 1'b0;
    base = cyc + 1;
    expect_at(0, IDLE, 0, 0, "reset_idle0");
    expect_at(1, IDLE, 0, 0, "reset_idle1");
    repeat (2) tick();

    // Nominal staircase T=4 D=3 H=5
    base = cyc + 1;
    expect_at(0,  RU, 0, 0, "nom_e0");
    expect_at(2,  RU, 0, 0, "nom_e2");
    expect_at(3,  RU, 1, 0, "nom_e3");
    expect_at(6,  RU, 2, 0, "nom_e6");
    expect_at(9,  RU, 3, 0, "nom_e9");
    expect_at(11, RU, 3, 0, "nom_e11");
    expect_at(12, HO, 4, 0, "nom_hold12");
    expect_at(16, HO, 4, 0, "nom_hold16");
    expect_at(17, RD, 4, 0, "nom_rd17");
    expect_at(19, RD, 4, 0, "nom_rd19");
    expect_at(20, RD, 3, 0, "nom_rd20");
    expect_at(23, RD, 2, 0, "nom_rd23");
    expect_at(26, RD, 1, 0, "nom_rd26");
    expect_at(28, RD, 1, 0, "nom_rd28");
    expect_at(29, DN, 0, 1, "nom_done29");
    expect_at(30, IDLE, 0, 1, "nom_idle30");
    expect_at(31, IDLE, 0, 1, "nom_idle31");
    done_q.push_back(8'd1);
    start_run(4, 3, 5);
    repeat (29) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();

    // Clamp and zero config: T=15 -> 8, D=0 -> 1, H=0 -> 1
    base = cyc + 1;
    expect_at(0,  RU, 0, 1, "clamp_e0");
    expect_at(1,  RU, 1, 1, "clamp_e1");
    expect_at(7,  RU, 7, 1, "clamp_e7");
    expect_at(8,  HO, 8, 1, "clamp_hold8");
    expect_at(9,  RD, 8, 1, "clamp_rd9");
    expect_at(10, RD, 7, 1, "clamp_rd10");
    expect_at(16, RD, 1, 1, "clamp_rd16");
    expect_at(17, DN, 0, 2, "clamp_done17");
    expect_at(18, IDLE, 0, 2, "clamp_idle18");
    done_q.push_back(8'd2);
    start_run(15, 0, 0);
    repeat (19) tick();

    // Stop mid-ramp at level 3, second stop in RAMP_DOWN ignored
    base = cyc + 1;
    expect_at(5,  RU, 2, 2, "stop_e5");
    expect_at(6,  RU, 3, 2, "stop_e6");
    expect_at(7,  RD, 3, 2, "stop_rd7");
    expect_at(8,  RD, 3, 2, "stop_rd8");
    expect_at(9,  RD, 2, 2, "stop_rd9");
    expect_at(10, RD, 2, 2, "stop_rd10");
    expect_at(11, RD, 1, 2, "stop_rd11");
    expect_at(13, DN, 0, 3, "stop_done13");
    expect_at(14, IDLE, 0, 3, "stop_idle14");
    done_q.push_back(8'd3);
    start_run(6, 2, 3);
    repeat (6) tick();
    stop = 1'b1; tick(); stop = 1'b0;
    repeat (2) tick();
    stop = 1'b1; tick(); stop = 1'b0;
    repeat (5) tick();

    // Abort in HOLD at level 5
    base = cyc + 1;
    expect_at(5, HO, 5, 3, "abort_hold5");
    expect_at(6, HO, 5, 3, "abort_hold6");
    expect_at(7, IDLE, 0, 3, "abort_idle7");
    expect_at(8, IDLE, 0, 3, "abort_idle8");
    start_run(5, 1, 10);
    repeat (6) tick();
    abort = 1'b1; tick(); abort = 1'b0;
    repeat (2) tick();

    // abort+stop+start together in IDLE
    base = cyc + 1;
    expect_at(0, IDLE, 0, 3, "prio_idle0");
    expect_at(1, IDLE, 0, 3, "prio_idle1");
    target_level = 4'd3; dwell_cfg = 8'd1; hold_cfg = 8'd1;
    abort = 1'b1; stop = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; stop = 1'b0; start = 1'b0;
    repeat (2) tick();

    // ena freeze for 10 edges during RAMP_UP, abort while frozen ignored
    base = cyc + 1;
    expect_at(2,  RU, 0, 3, "ena_e2");
    expect_at(8,  RU, 0, 3, "ena_frozen8");
    expect_at(12, RU, 0, 3, "ena_frozen12");
    expect_at(13, RU, 0, 3, "ena_e13");
    expect_at(14, RU, 1, 3, "ena_e14");
    expect_at(17, RU, 1, 3, "ena_e17");
    expect_at(18, HO, 2, 3, "ena_hold18");
    expect_at(19, RD, 2, 3, "ena_rd19");
    expect_at(22, RD, 2, 3, "ena_rd22");
    expect_at(23, RD, 1, 3, "ena_rd23");
    expect_at(27, DN, 0, 4, "ena_done27");
    expect_at(28, IDLE, 0, 4, "ena_idle28");
    done_q.push_back(8'd4);
    start_run(2, 4, 1);
    repeat (2) tick();
    ena = 1'b0;
    repeat (5) tick();
    abort = 1'b1; tick(); abort = 1'b0;
    repeat (4) tick();
    ena = 1'b1;
    repeat (17) tick();

    // Async reset between edges mid-run
    base = cyc + 1;
    expect_at(2, RU, 2, 4, "rst_pre2");
    expect_at(3, IDLE, 0, 0, "rst_async3");
    expect_at(4, IDLE, 0, 0, "rst_held4");
    expect_at(6, IDLE, 0, 0, "rst_after6");
    start_run(8, 1, 4);
    repeat (3) tick();
    #1 rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    repeat (2) tick();

    // T=0 start goes straight to DONE
    base = cyc + 1;
    expect_at(0, DN, 0, 1, "zero_done0");
    expect_at(1, IDLE, 0, 1, "zero_idle1");
    done_q.push_back(8'd1);
    start_run(0, 5, 5);
    repeat (2) tick();

    // 255 more zero-target runs: run_count wraps to 0
    base = cyc + 1;
    expect_at(0,   DN, 0, 2, "wrap_done0");
    expect_at(1,   IDLE, 0, 2, "wrap_idle1");
    expect_at(508, DN, 0, 0, "wrap_done508");
    expect_at(509, IDLE, 0, 0, "wrap_idle509");
    expect_at(510, IDLE, 0, 0, "wrap_idle510");
    for (int j = 0; j < 255; j++) done_q.push_back(8'(j + 2));
    target_level = 4'd0;
    start = 1'b1;
    repeat (509) tick();
    start = 1'b0;
    repeat (3) tick();

    for (int w = 0; w < 100 && exp_q.size() > 0; w++) tick();
    n_vec++;
    if (exp_q.size() != 0 || done_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d snapshots and %0d done pulses pending, want 0 and 0",
               exp_q.size(), done_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
